branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor: direct-mapped BTB with a 2-bit saturating direction counter per entry.
- Looked up combinationally in IF with the current PC; trained from the MEM stage, where branches resolve.
- Also produces the mispredict/redirect decision for the flush logic, replacing the always-not-taken policy.
- Keeps saturating performance counters for branches resolved and mispredicts.

Parameters:
XLEN, 32, address/data width in bits
ENTRIES, 64, BTB entries; power of two, 2..1024
TAG_W, 8, tag bits stored per entry; IDX_W = log2(ENTRIES), and TAG_W + IDX_W + 2 <= XLEN
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
if_pc  in  XLEN  PC being fetched
if_valid  in  1  fetch slot valid (gates lookup statistics only)
pred_taken  out  1  predict taken for if_pc
pred_target  out  XLEN  predicted next PC: target if taken, else if_pc+4
upd_valid  in  1  MEM-stage control-flow instruction resolving this cycle
upd_is_jump  in  1  1 = jal/jalr (always taken), 0 = conditional branch
upd_pc  in  XLEN  PC of resolving instruction
upd_taken  in  1  actual direction
upd_target  in  XLEN  actual taken target
upd_pred_taken  in  1  prediction carried down the pipe for this instruction
upd_pred_target  in  XLEN  predicted next PC carried down the pipe
mispredict  out  1  flush IF/ID and ID/EX, load redirect_pc
redirect_pc  out  XLEN  correct next PC
perf_branches  out  CNT_W  resolved control-flow count
perf_mispredicts  out  CNT_W  mispredict count

Behaviour:
- Clocking and reset: one clock domain (clk). reset is synchronous and active-high.
- Address split:
  - index = PC[IDX_W+1:2]
  - tag = PC[IDX_W+TAG_W+1:IDX_W+2]
  - PC[1:0] ignored.
- Entry state: valid(1), tag(TAG_W), target(XLEN), ctr(2).
  - Flop-based so reset can clear it in one cycle.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag matches.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4, mod 2^XLEN.
- Resolve (combinational on upd_* inputs):
  - actual_next = upd_taken ? upd_target : upd_pc+4.
  - predicted_next = upd_pred_taken ? upd_pred_target : upd_pc+4.
  - mispredict = upd_valid && (actual_next != predicted_next).
  - redirect_pc = actual_next.
  - A correct direction with a wrong target counts as a mispredict.
  - mispredict is 0 whenever upd_valid = 0.
- Training (registered, applied at the clk edge when upd_valid = 1):
  - Hit, branch: ctr += 1 if taken, -= 1 if not taken; saturates at 3 and 0. If taken, target <= upd_target.
  - Hit, jump: ctr <= 3; target <= upd_target.
  - Miss, taken: allocate/overwrite the entry. valid <= 1, tag, target <= upd_target; ctr <= 2 for a branch, 3 for a jump.
  - Miss, not taken: no state change.
- Simultaneous lookup and update to the same index: the lookup sees pre-update state; the new state is visible on the next cycle. No bypass.
- Performance counters:
  - perf_branches += 1 on every upd_valid.
  - perf_mispredicts += 1 when mispredict.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - if_valid does not gate training.
- Reset:
  - All valid <= 0; ctr <= 1 (weakly not-taken); targets and tags are don't-care.
  - Both perf counters <= 0.
  - Outputs after reset: pred_taken = 0, pred_target = if_pc+4. mispredict follows upd_* (0 if upd_valid = 0).
- Reset asserted in the same cycle as upd_valid: reset wins; no training, no count.
- Reset mid-operation discards all learned state.

Test Plan:
1. Reset then lookup if_pc=0x100 -> pred_taken=0, pred_target=0x104, both perf counters 0.
2. Update pc=0x100 branch taken target=0x80 with upd_pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle, lookup 0x100 -> pred_taken=1, pred_target=0x80. perf_branches=1, perf_mispredicts=1.
3. Same branch not-taken three times:
   - ctr goes 2 -> 1 -> 0 -> 0 (saturates).
   - pred_taken=0 after the first update.
   - Fourth update taken -> ctr=1, still predicts not-taken.
4. Aliasing, ENTRIES=64: train pc=0x100 taken, then pc=0x200 taken (same index, different tag) -> lookup 0x100 misses (pred_target=0x104), lookup 0x200 hits.
5. Jump at 0x40 to 0x400: predicted taken with upd_pred_target=0x300 -> mispredict=1, redirect_pc=0x400, ctr=3. Same lookup/update cycle returns the old target 0x300; the next cycle returns 0x400.
6. CNT_W=4:
   - 20 mispredicting updates -> both counters hold at 15.
   - reset asserted together with upd_valid -> counters 0, entry not allocated.

Source files
------------

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, MEM-stage resolve/train and perf signals of the branch predictor
interface branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            upd_valid;
  logic            upd_is_jump;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  logic [CNT_W-1:0] perf_branches;
  logic [CNT_W-1:0] perf_mispredicts;

  modport master (
    output if_valid, if_pc,
    output upd_valid, upd_is_jump, upd_pc, upd_taken, upd_target,
    output upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc,
    input  perf_branches, perf_mispredicts
  );

  modport slave (
    input  if_valid, if_pc,
    input  upd_valid, upd_is_jump, upd_pc, upd_taken, upd_target,
    input  upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc,
    output perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters, redirect decision and perf counters
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 32
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [CNT_W-1:0]   perf_br_q, perf_br_d;
  logic [CNT_W-1:0]   perf_mp_q, perf_mp_d;

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             if_hit, upd_hit;
  logic [XLEN-1:0]  actual_next, predicted_next;

  // if_valid would only gate lookup statistics, none of which are kept here
  logic unused_if_valid;
  assign unused_if_valid = bus.if_valid;

  assign if_idx  = bus.if_pc[IDX_W+1:2];
  assign if_tag  = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign bus.pred_taken  = if_hit && ctr_q[if_idx][1];
  assign bus.pred_target = bus.pred_taken ? target_q[if_idx] : bus.if_pc + XLEN'(4);

  assign actual_next     = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);
  assign predicted_next  = bus.upd_pred_taken ? bus.upd_pred_target : bus.upd_pc + XLEN'(4);
  assign bus.mispredict  = bus.upd_valid && (actual_next != predicted_next);
  assign bus.redirect_pc = actual_next;

  assign bus.perf_branches    = perf_br_q;
  assign bus.perf_mispredicts = perf_mp_q;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bus.upd_valid) begin
      if (upd_hit) begin
        if (bus.upd_is_jump) begin
          ctr_d[upd_idx]    = 2'd3;
          target_d[upd_idx] = bus.upd_target;
        end else if (bus.upd_taken) begin
          if (ctr_q[upd_idx] != 2'd3) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = bus.upd_target;
        end else if (ctr_q[upd_idx] != 2'd0) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = bus.upd_target;
        ctr_d[upd_idx]    = bus.upd_is_jump ? 2'd3 : 2'd2;
      end
    end
  end

  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (bus.upd_valid && (perf_br_q != '1)) perf_br_d = perf_br_q + CNT_W'(1);
    if (bus.mispredict && (perf_mp_q != '1)) perf_mp_d = perf_mp_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      perf_br_q <= '0;
      perf_mp_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'd1;
    end else begin
      valid_q   <= valid_d;
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
      ctr_q     <= ctr_d;
    end
  end

  // Tag/target payload is only meaningful behind valid, so it needs no reset
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized scoreboard bench for branch_predictor against a behavioural model
module tb_branch_predictor;
  localparam int XLEN    = 32;
  localparam int ENTRIES = 64;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_predictor #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          v;
    int unsigned tag;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        mis;
    logic [31:0] redir;
    int unsigned pb;
    int unsigned pm;
  } exp_t;

  ent_t        m [ENTRIES];
  int unsigned m_pb, m_pm;
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  task automatic model_lookup(input logic [31:0] pc, output logic taken, output logic [31:0] tgt);
    int unsigned i;
    i = idx_of(pc);
    taken = m[i].v && (m[i].tag == tag_of(pc)) && (m[i].ctr >= 2);
    tgt = taken ? m[i].tgt : pc + 32'd4;
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m[i].v   = 1'b0;
      m[i].ctr = 1;
    end
    m_pb = 0;
    m_pm = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // One cycle: drive inputs, queue expected outputs, then advance the model past the next edge
  task automatic step(input bit rst, input logic [31:0] ipc, input bit uv, input bit uj,
                      input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                      input bit upt, input logic [31:0] uptgt);
    exp_t        e;
    logic [31:0] an, pn;
    int unsigned i;
    bit          hit;
    @(posedge clk);
    #1;
    reset               = rst;
    bus.if_pc           = ipc;
    bus.if_valid        = 1'($urandom_range(0, 1));
    bus.upd_valid       = uv;
    bus.upd_is_jump     = uj;
    bus.upd_pc          = upc;
    bus.upd_taken       = ut;
    bus.upd_target      = utgt;
    bus.upd_pred_taken  = upt;
    bus.upd_pred_target = uptgt;

    model_lookup(ipc, e.pt, e.ptgt);
    an = ut ? utgt : upc + 32'd4;
    pn = upt ? uptgt : upc + 32'd4;
    e.mis   = uv && (an != pn);
    e.redir = an;
    e.pb    = m_pb;
    e.pm    = m_pm;
    sb.push_back(e);

    if (rst) begin
      model_reset();
    end else if (uv) begin
      i   = idx_of(upc);
      hit = m[i].v && (m[i].tag == tag_of(upc));
      if (hit && uj) begin
        m[i].ctr = 3;
        m[i].tgt = utgt;
      end else if (hit) begin
        m[i].ctr = ut ? ((m[i].ctr < 3) ? m[i].ctr + 1 : 3) : ((m[i].ctr > 0) ? m[i].ctr - 1 : 0);
        if (ut) m[i].tgt = utgt;
      end else if (ut) begin
        m[i].v   = 1'b1;
        m[i].tag = tag_of(upc);
        m[i].tgt = utgt;
        m[i].ctr = uj ? 3 : 2;
      end
      if (m_pb < CNT_MAX) m_pb++;
      if (e.mis && m_pm < CNT_MAX) m_pm++;
    end
  endtask

  task automatic look(input logic [31:0] ipc);
    step(1'b0, ipc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Small PC pool so indices and tags collide often; bits above the tag vary to probe partial tags
  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = 32'($urandom_range(0, 3)) << 16;
    pc = pc | (32'($urandom_range(0, 3)) << 8);
    pc = pc | (32'($urandom_range(0, 7)) << 2);
    if ($urandom_range(0, 7) == 0) pc = pc | 32'($urandom_range(0, 3));
    return pc;
  endfunction

  task automatic rand_step();
    bit          rst, uv, uj, ut, upt;
    logic [31:0] ipc, upc, utgt, uptgt, lt;
    logic        lp;
    rst  = ($urandom_range(0, 99) == 0);
    ipc  = rand_pc();
    uv   = ($urandom_range(0, 3) != 0);
    uj   = ($urandom_range(0, 4) == 0);
    upc  = ($urandom_range(0, 3) == 0) ? ipc : rand_pc();
    ut   = uj ? 1'b1 : 1'($urandom_range(0, 1));
    utgt = {20'h0, 10'($urandom_range(0, 15) * 64), 2'b00};
    model_lookup(upc, lp, lt);
    if ($urandom_range(0, 1) == 0) begin
      upt   = lp;
      uptgt = lt;
    end else begin
      upt   = 1'($urandom_range(0, 1));
      uptgt = ($urandom_range(0, 1) == 0) ? utgt : $urandom;
    end
    step(rst, ipc, uv, uj, upc, ut, utgt, upt, uptgt);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("pred_taken",       32'(bus.pred_taken),       32'(e.pt));
      chk("pred_target",      bus.pred_target,           e.ptgt);
      chk("mispredict",       32'(bus.mispredict),       32'(e.mis));
      chk("redirect_pc",      bus.redirect_pc,           e.redir);
      chk("perf_branches",    32'(bus.perf_branches),    e.pb);
      chk("perf_mispredicts", 32'(bus.perf_mispredicts), e.pm);
    end
  end

  initial begin
    reset = 1'b1;
    bus.if_pc = '0;
    bus.if_valid = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_is_jump = 1'b0;
    bus.upd_pc = '0;
    bus.upd_taken = 1'b0;
    bus.upd_target = '0;
    bus.upd_pred_taken = 1'b0;
    bus.upd_pred_target = '0;
    model_reset();

    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look(32'h100);
    step(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    look(32'h100);
    step(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    look(32'h100);
    step(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    look(32'h100);
    step(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    step(1'b0, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h900, 1'b0, 32'h0);
    look(32'h100);
    look(32'h200);
    step(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 32'h0);
    step(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h400, 1'b1, 32'h300);
    look(32'h40);

    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++)
      step(1'b0, 32'h500, 1'b1, 1'b0, 32'h1000 + 32'(i * 4), 1'b1, 32'h2000, 1'b0, 32'h0);
    look(32'h500);
    step(1'b1, 32'h500, 1'b1, 1'b0, 32'h500, 1'b1, 32'h700, 1'b0, 32'h0);
    look(32'h500);

    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3000; i++) rand_step();
    look(32'h0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(500_000);
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
